// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing the single FIFO write port among
// N requesters, one bounded burst per grant, with wfull back-pressure passed
// straight through to the granted requester as a valid/ready handshake.
// Optional feature: define FIFO_WR_ARB_STATS_EN to add per-requester
// accepted-word counters on the extra output port 'count'.
module fifo_wr_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int BURST = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data,
    input  logic [N-1:0]         last,
    output logic [N-1:0]         ready,
    output logic [N-1:0]         gnt,
    output logic                 busy,
    output logic [WIDTH-1:0]     wdata,
    output logic                 winc,
    input  logic                 wfull
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [N*32-1:0]      count
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [BW-1:0]   beats;

    logic            found;
    logic [PW-1:0]   sel;
    int              idx;

    logic            own_req;
    logic            own_last;
    logic [WIDTH-1:0] own_data;
    logic            xfer;
    logic            final_beat;

    // Round-robin search: first requester above the last owner, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx[PW-1:0];
            end
        end
    end

    // Owner's signals; ptr holds the current owner while in a burst.
    always_comb begin
        own_req    = req[ptr];
        own_last   = last[ptr];
        own_data   = data[ptr*WIDTH +: WIDTH];
        final_beat = (beats == BW'(BURST - 1));
        xfer       = (state == ST_BURST) && own_req && !wfull && !reset;
    end

    // Write-port outputs: combinational from wfull so back-pressure costs no cycle.
    always_comb begin
        winc  = xfer;
        ready = '0;
        wdata = '0;
        if (state == ST_BURST) begin
            wdata = own_data;
            if (!wfull && !reset) begin
                ready = gnt;
            end
        end
    end

    // Arbiter FSM: grant in IDLE, count beats and release in BURST.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= PW'(N - 1);
            beats <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_BURST;
                        gnt   <= {{(N-1){1'b0}}, 1'b1} << sel;
                        busy  <= 1'b1;
                        ptr   <= sel;
                        beats <= '0;
                    end
                end
                ST_BURST: begin
                    if (!own_req || (xfer && (own_last || final_beat))) begin
                        state <= ST_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        beats <= '0;
                    end else if (xfer) begin
                        beats <= beats + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    beats <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // Per-requester accepted-word counters, wrapping at 2^32.
    for (genvar i = 0; i < N; i++) begin : g_stats
        always_ff @(posedge clk) begin
            if (reset) begin
                count[i*32 +: 32] <= '0;
            end else if (xfer && gnt[i]) begin
                count[i*32 +: 32] <= count[i*32 +: 32] + 32'd1;
            end
        end
    end
`endif

endmodule
